// File: rtl/rgbw_spi_frame_master_pkg.sv
// rgbw_spi_pkg: shared definitions for the RGBW lamp configuration SPI link.
//   FRAME_BYTES  number of bytes in one lamp configuration frame
//   LINT..WHITE  byte position of each lamp register within the frame; the
//                slave side and the deserializer use the same indices
//   state_t      frame master state encoding
package rgbw_spi_pkg;

   localparam int FRAME_BYTES = 7;

   localparam logic [2:0] LINT      = 3'd0;
   localparam logic [2:0] RED       = 3'd1;
   localparam logic [2:0] GREEN     = 3'd2;
   localparam logic [2:0] BLUE      = 3'd3;
   localparam logic [2:0] COLOR_IDX = 3'd4;
   localparam logic [2:0] MODE      = 3'd5;
   localparam logic [2:0] WHITE     = 3'd6;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      GAP,
      HOLD,
      CSWAIT
   } state_t;

endpackage

// File: rtl/rgbw_spi_frame_master_byte_shifter.sv
// spi_byte_shifter: MSB-first byte serialiser driving MOSI from a flop.
//   clk, reset  system clock, synchronous active-low reset
//   load        present value[7] on mosi and arm the remaining seven bits
//   value       byte to send
//   sck_fall    advance to the next bit (asserted on the SCK falling edge)
//   clear       drive mosi low and disarm
//   mosi        serial data out
//   last_bit    the bit currently on mosi is bit 0 of the byte
module spi_byte_shifter (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] value,
   input  logic       sck_fall,
   input  logic       clear,
   output logic       mosi,
   output logic       last_bit
);

   logic [6:0] rest;     // bits still to be presented, next one in [6]
   logic [2:0] bit_cnt;  // index of the bit currently on mosi, 7 -> 0

   always_ff @(posedge clk) begin
      if (!reset) begin
         mosi    <= 1'b0;
         rest    <= '0;
         bit_cnt <= '0;
      end else if (clear) begin
         mosi    <= 1'b0;
         rest    <= '0;
         bit_cnt <= '0;
      end else if (load) begin
         mosi    <= value[7];
         rest    <= value[6:0];
         bit_cnt <= 3'd7;
      end else if (sck_fall) begin
         mosi    <= rest[6];
         rest    <= {rest[5:0], 1'b0};
         bit_cnt <= bit_cnt - 3'd1;
      end
   end

   assign last_bit = (bit_cnt == 3'd0);

endmodule

// File: rtl/rgbw_spi_frame_master.sv
// rgbw_spi_frame_master: SPI mode-0 master sending one 7-byte RGBW lamp
// configuration frame under a single chip-select assertion.
//   clk, reset        system clock, synchronous active-low reset
//   start             one-cycle frame request, honoured only while idle
//   lint_in..white_in frame bytes 0..6, latched on the accepted start
//   busy              frame in progress, including the CS idle time
//   done              one-cycle pulse as cs_n returns high
//   byte_idx          index of the byte on the wire, 0 when idle
//   sck, mosi, cs_n   SPI bus (CPOL=0, CPHA=0), all straight from flops
module rgbw_spi_frame_master
   import rgbw_spi_pkg::*;
#(
   parameter int unsigned SCK_DIV    = 4,  // clk cycles per SCK half-period
   parameter int unsigned GAP_CYCLES = 8,  // extra SCK-low cycles between bytes
   parameter int unsigned CS_IDLE    = 4   // min cs_n high time between frames
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] lint_in,
   input  logic [7:0] red_in,
   input  logic [7:0] green_in,
   input  logic [7:0] blue_in,
   input  logic [7:0] color_idx_in,
   input  logic [7:0] mode_in,
   input  logic [7:0] white_in,
   output logic       busy,
   output logic       done,
   output logic [2:0] byte_idx,
   output logic       sck,
   output logic       mosi,
   output logic       cs_n
);

   localparam logic [7:0] DIV_M1 = 8'(SCK_DIV - 1);
   localparam logic [7:0] GAP_M1 = 8'(GAP_CYCLES - 1);
   localparam logic [7:0] CSW_M2 = 8'(CS_IDLE - 2);

   state_t     state;
   logic [7:0] half_cnt;    // position within the current SCK half-period
   logic [7:0] wait_cnt;    // GAP and CSWAIT duration counter
   logic       byte_end;    // current low phase closes a non-final byte
   logic       frame_end;   // current low phase closes the final byte
   logic [7:0] shadow [FRAME_BYTES];

   logic       half_end;
   logic       fall_now;
   logic [2:0] next_idx;
   logic       shift_load;
   logic       shift_fall;
   logic       shift_clear;
   logic [7:0] shift_value;
   logic       last_bit;

   // NOTE: every output of this block is assigned on every pass, so no latch
   // can be inferred.
   always_comb begin
      half_end    = (half_cnt == DIV_M1);
      fall_now    = (state == SHIFT) && sck && half_end;
      next_idx    = (byte_idx == WHITE) ? WHITE : byte_idx + 3'd1;
      // The first byte comes straight from the port because the shadow
      // registers are only written on this same edge.
      shift_load  = ((state == IDLE) && start) ||
                    (fall_now && last_bit && (byte_idx != WHITE));
      shift_fall  = fall_now && !last_bit;
      shift_clear = (state == HOLD) && half_end;
      shift_value = (state == IDLE) ? lint_in : shadow[next_idx];
   end

   spi_byte_shifter u_shifter (
      .clk      (clk),
      .reset    (reset),
      .load     (shift_load),
      .value    (shift_value),
      .sck_fall (shift_fall),
      .clear    (shift_clear),
      .mosi     (mosi),
      .last_bit (last_bit)
   );

   // NOTE: all state is updated with non-blocking assignments so every
   // register sees the values from before this edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         half_cnt  <= '0;
         wait_cnt  <= '0;
         byte_end  <= 1'b0;
         frame_end <= 1'b0;
         byte_idx  <= LINT;
         sck       <= 1'b0;
         cs_n      <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         // NOTE: the shadow bank is only seven bytes of flops, so it is
         // cleared with everything else rather than left to power-up values.
         for (int i = 0; i < FRAME_BYTES; i++) shadow[i] <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  shadow[LINT]      <= lint_in;
                  shadow[RED]       <= red_in;
                  shadow[GREEN]     <= green_in;
                  shadow[BLUE]      <= blue_in;
                  shadow[COLOR_IDX] <= color_idx_in;
                  shadow[MODE]      <= mode_in;
                  shadow[WHITE]     <= white_in;
                  cs_n     <= 1'b0;
                  busy     <= 1'b1;
                  byte_idx <= LINT;
                  half_cnt <= '0;
                  state    <= SETUP;
               end
            end

            SETUP: begin
               if (half_end) begin
                  half_cnt <= '0;
                  sck      <= 1'b1;
                  state    <= SHIFT;
               end else begin
                  half_cnt <= half_cnt + 8'd1;
               end
            end

            SHIFT: begin
               if (!half_end) begin
                  half_cnt <= half_cnt + 8'd1;
               end else begin
                  half_cnt <= '0;
                  if (sck) begin
                     // Falling edge: the shifter moves on in parallel; after
                     // bit 0 the wire already carries the next byte.
                     sck <= 1'b0;
                     if (last_bit) begin
                        if (byte_idx == WHITE) begin
                           frame_end <= 1'b1;
                        end else begin
                           byte_idx <= next_idx;
                           byte_end <= 1'b1;
                        end
                     end
                  end else if (frame_end) begin
                     frame_end <= 1'b0;
                     state     <= HOLD;
                  end else if (byte_end && (GAP_CYCLES != 0)) begin
                     byte_end <= 1'b0;
                     wait_cnt <= '0;
                     state    <= GAP;
                  end else begin
                     byte_end <= 1'b0;
                     sck      <= 1'b1;
                  end
               end
            end

            GAP: begin
               if (wait_cnt == GAP_M1) begin
                  half_cnt <= '0;
                  sck      <= 1'b1;
                  state    <= SHIFT;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end

            HOLD: begin
               if (half_end) begin
                  half_cnt <= '0;
                  wait_cnt <= '0;
                  cs_n     <= 1'b1;
                  done     <= 1'b1;
                  byte_idx <= LINT;
                  // The IDLE cycle in which the next start is sampled still
                  // has cs_n high, so CSWAIT covers CS_IDLE-1 cycles and a
                  // start on the first non-busy cycle gives exactly CS_IDLE.
                  if (CS_IDLE <= 1) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     state <= CSWAIT;
                  end
               end else begin
                  half_cnt <= half_cnt + 8'd1;
               end
            end

            CSWAIT: begin
               if (wait_cnt == CSW_M2) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/rgbw_spi_frame_master.md
Name: rgbw_spi_frame_master

Overview:
- SPI mode-0 master that transmits one complete 7-byte RGBW lamp configuration frame to the lamp controller's SPI slave port.
- It is the transmit end of the existing receiver/deserializer path.
- Used on the host/test side: in the integration bench, and in a companion tile that drives the lamp.
- Latches seven register values on a start request, then serialises them MSB-first under a single chip-select assertion, with a configurable SCK rate and inter-byte gap.

Parameters:
- SCK_DIV, 4: clk cycles per SCK half-period; legal range 2..255.
- GAP_CYCLES, 8: clk cycles SCK is held low between bytes, with CS still asserted; legal range 0..255.
- CS_IDLE, 4: minimum clk cycles cs_n stays high after a frame before the next start is accepted; legal range 1..255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- start  in  1  single-cycle request; sampled only when busy=0
- lint_in  in  8  byte 0
- red_in  in  8  byte 1
- green_in  in  8  byte 2
- blue_in  in  8  byte 3
- color_idx_in  in  8  byte 4
- mode_in  in  8  byte 5
- white_in  in  8  byte 6
- busy  out  1  high from the cycle after start until CS_IDLE has expired
- done  out  1  one-cycle pulse, coincident with cs_n rising
- byte_idx  out  3  index of the byte currently on the wire (0..6); 0 when idle
- sck  out  1  SPI clock; idle low (CPOL=0)
- mosi  out  1  SPI data; changes on SCK falling edge, stable at rising edge (CPHA=0)
- cs_n  out  1  chip select, active low

Behaviour:
- Clock and reset: clock clk. Reset is synchronous, active-low, signal name reset.
- Reset values: sck=0, mosi=0, cs_n=1, busy=0, done=0, byte_idx=0, state=IDLE. All counters and the shadow registers are cleared.
- Reset mid-frame: on the next edge, the outputs take their reset values. No partial frame is completed.
- IDLE:
  - start=1 latches all 7 inputs into shadow registers.
  - Next cycle: cs_n=0, busy=1, mosi=lint_in[7]. Go to SETUP.
  - Input changes after the latch cycle have no effect on the current frame.
- SETUP: hold SCK_DIV cycles with sck=0, then go to SHIFT.
- SHIFT, per bit:
  - sck=1 for SCK_DIV cycles, then sck=0 for SCK_DIV cycles.
  - On the high-to-low transition, mosi presents the next bit.
  - 8 bits take 16*SCK_DIV cycles.
- After bit 0 of a byte:
  - If byte_idx<6: go to GAP. Keep sck=0 and cs_n=0 for GAP_CYCLES. At GAP entry, increment byte_idx and set mosi=bit7 of the next byte. Return to SHIFT.
  - If GAP_CYCLES=0: skip GAP. The next byte's first rising edge follows directly after the SCK_DIV low phase.
  - If byte_idx==6: go to HOLD.
- HOLD: sck=0 for SCK_DIV cycles. Then cs_n=1, done=1 for one cycle, mosi=0, byte_idx=0. Go to CSWAIT.
- CSWAIT: cs_n=1 for CS_IDLE cycles. busy falls when it expires, and the block returns to IDLE.
- start while busy=1: ignored. It is not queued.
- Frame length, cs_n falling to rising: SCK_DIV + 7*16*SCK_DIV + 6*GAP_CYCLES + SCK_DIV clk cycles. The defaults give 504.
- Glitch-free outputs: sck, mosi and cs_n are driven directly from flops, with no combinational decode.
- Counters:
  - half-period counter: 8-bit, wraps at SCK_DIV-1
  - bit counter: 3-bit, counts 7→0
  - byte counter: 3-bit, saturates at 6
  - gap/idle counter: 8-bit

Decomposition:
- Package rgbw_spi_pkg holds:
  - FRAME_BYTES=7
  - byte-index constants: LINT=0, RED=1, GREEN=2, BLUE=3, COLOR_IDX=4, MODE=5, WHITE=6
  - state encoding: IDLE, SETUP, SHIFT, GAP, HOLD, CSWAIT
- The slave side and the deserializer use the same byte-index constants.
- One sub-module, spi_byte_shifter:
  - Inputs: load and an 8-bit value; sck_fall enable.
  - Outputs: mosi and a last_bit flag.
  - The top-level FSM owns cs_n, sck timing and byte sequencing.

Test Plan:
- Defaults; start with bytes 0x11,0x22,0x33,0x44,0x05,0x02,0xAA → a reference SPI mode-0 slave model captures exactly those 7 bytes in order. cs_n is low for 504 cycles. done pulses once.
- Capture with the existing spiSlave + rgbw_data_dispencer instance → lint=0x11, red=0x22 … white=0xAA appear on the register outputs.
- Second start pulse at cycle 100 of a frame → ignored. Only 7 bytes are received. busy stays continuous.
- Reset asserted at byte 3, bit 4 → next edge: cs_n=1, sck=0, mosi=0, busy=0. A new start then sends a full, clean frame.
- SCK_DIV=2, GAP_CYCLES=0, bytes 0xFF,0x00,0x80,0x01,0x7F,0xFE,0x55 → no SCK glitch. The sck high/low phases are each exactly 2 cycles. cs_n is low for 228 cycles.
- Back-to-back starts at the first cycle busy=0 → cs_n is high for exactly CS_IDLE cycles between the frames.
